// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per cycle. Results are {remainder, quotient}.
// Signed and unsigned modes share one datapath: magnitudes in, sign fix-up out.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 annul_i,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     dividend_i,
  input  logic [WIDTH-1:0]     divisor_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 stallreq_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_quo;
  logic [WIDTH-1:0]     r_dvsr;
  logic                 r_sgn_a;
  logic                 r_sgn_b;
  logic [2*WIDTH-1:0]   r_result;

  logic                 w_accept;
  logic                 w_last;
  logic                 w_stall;
  logic                 w_ready;
  logic [WIDTH:0]       w_part;
  logic [WIDTH:0]       w_diff;
  logic [WIDTH-1:0]     w_rem_nxt;
  logic [WIDTH-1:0]     w_quo_nxt;
  logic [WIDTH-1:0]     w_rem_fix;
  logic [WIDTH-1:0]     w_quo_fix;

  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
    return '0 - v;
  endfunction

  // The most negative value negates to itself, which reads correctly as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? f_neg(v) : v;
  endfunction

  assign w_accept = start_i & ~annul_i;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // Restoring step: partial remainder stays below the divisor, so WIDTH+1 bits suffice.
  assign w_part    = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_part - {1'b0, r_dvsr};
  assign w_rem_nxt = w_diff[WIDTH] ? w_part[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};

  assign w_quo_fix = (r_sgn_a ^ r_sgn_b) ? f_neg(w_quo_nxt) : w_quo_nxt;
  assign w_rem_fix = r_sgn_a ? f_neg(w_rem_nxt) : w_rem_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_stall = 1'b1;
          w_next  = (divisor_i == '0) ? S_DIVZERO : S_ON;
        end
      end
      S_DIVZERO: begin
        w_stall = 1'b1;
        w_next  = annul_i ? S_IDLE : S_END;
      end
      S_ON: begin
        w_stall = 1'b1;
        if (annul_i) begin
          w_next = S_IDLE;
        end else if (w_last) begin
          w_next = S_END;
        end
      end
      S_END: begin
        w_ready = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt <= '0;
          end
        end
        S_DIVZERO: begin
          if (!annul_i) begin
            r_result <= {r_rem, {WIDTH{1'b1}}};
          end
        end
        S_ON: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (!annul_i && w_last) begin
            r_result <= {w_rem_fix, w_quo_fix};
          end
        end
        default: ;
      endcase
    end
  end

  // For a zero divisor r_rem carries the raw dividend straight through to the result.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_accept) begin
      r_sgn_a <= signed_i & dividend_i[WIDTH-1];
      r_sgn_b <= signed_i & divisor_i[WIDTH-1];
      r_dvsr  <= f_mag(divisor_i, signed_i);
      r_quo   <= f_mag(dividend_i, signed_i);
      r_rem   <= (divisor_i == '0) ? dividend_i : '0;
    end else if (r_state == S_ON) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
    end
  end

  assign result_o   = r_result;
  assign ready_o    = w_ready;
  assign stallreq_o = w_stall & ~rst;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: vector table plus hand-written annul/reset/back-to-back sequences,
// with results checked through a scoreboard queue popped on every ready_o pulse.
module tb_div_seq;
  localparam int W  = 32;
  localparam int NV = 14;

  typedef struct {
    logic           sgn;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_i;
  logic           annul_i;
  logic           signed_i;
  logic [W-1:0]   dividend_i;
  logic [W-1:0]   divisor_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           stallreq_o;

  int             n_chk   = 0;
  int             n_fail  = 0;
  int             n_ready = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] mon_exp;
  logic [2*W-1:0] last_exp = '0;
  vec_t           vecs[NV];

  always #5 clk = ~clk;

  div_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .annul_i    (annul_i),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    if (b == '0) return {a, {W{1'b1}}};
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {{W{1'b0}}, a};
    sa = a;
    sb = b;
    return {W'(sa % sb), W'(sa / sb)};
  endfunction

  always @(negedge clk) begin
    if (ready_o === 1'b1) begin
      n_ready++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ready: result %h with nothing outstanding", result_o);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", result_o, mon_exp);
      end
    end
  end

  task automatic wait_ready(input int exp_lat, input string name);
    int lat    = 0;
    int stalls = 0;
    for (int c = 1; c <= exp_lat + 8; c++) begin
      @(negedge clk);
      if (ready_o === 1'b1) begin
        lat = c;
        break;
      end
      if (stallreq_o === 1'b1) stalls++;
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_stall_cycles"}, stalls, exp_lat - 1);
    check({name, "_stall_end"}, stallreq_o, 0);
    if (lat == 0) exp_q.delete();
  endtask

  task automatic do_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] exp, input string name);
    @(posedge clk);
    #1;
    start_i    = 1'b1;
    signed_i   = sgn;
    dividend_i = a;
    divisor_i  = b;
    #1;
    check({name, "_stall0"}, stallreq_o, 1);
    exp_q.push_back(exp);
    last_exp = exp;
    @(posedge clk);
    #1 start_i = 1'b0;
    wait_ready((b == '0) ? 2 : W + 1, name);
    @(negedge clk);
    check({name, "_ready_once"}, ready_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
    dividend_i = '0; divisor_i = '0;

    vecs[0]  = '{1'b0, 32'd100,       32'd7,        64'h00000002_0000000E};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,        64'hFFFFFFFF_FFFFFFFD};
    vecs[2]  = '{1'b1, 32'd7,         32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
    vecs[3]  = '{1'b0, 32'h12345678,  32'd0,        64'h12345678_FFFFFFFF};
    vecs[4]  = '{1'b1, 32'h12345678,  32'd0,        64'h12345678_FFFFFFFF};
    vecs[5]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 64'h00000000_80000000};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF,  32'd1,        64'h00000000_FFFFFFFF};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 64'h00000000_00000001};
    vecs[8]  = '{1'b0, 32'd5,         32'd10,       64'h00000005_00000000};
    vecs[9]  = '{1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE, 64'hFFFFFFFF_00000003};
    vecs[10] = '{1'b0, 32'h80000000,  32'd3,        64'h00000002_2AAAAAAA};
    vecs[11] = '{1'b1, 32'h80000000,  32'd2,        64'h00000000_C0000000};
    vecs[12] = '{1'b0, 32'h80000000,  32'hFFFFFFFF, 64'h80000000_00000000};
    vecs[13] = '{1'b1, 32'hFFFFFFF0,  32'd0,        64'hFFFFFFF0_FFFFFFFF};

    #12;
    check("rst_result", result_o, 0);
    check("rst_ready", ready_o, 0);
    check("rst_stall", stallreq_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < NV; i++)
      do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? W'($urandom_range(1, 15)) : $urandom;
      do_op(i[0], ra, rb, model(i[0], ra, rb), $sformatf("rnd%0d", i));
    end

    // Annul in cycle 10 of a division: back to IDLE, no ready, result untouched.
    @(posedge clk);
    #1 start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd3;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 annul_i = 1'b1;
    @(posedge clk);
    #1 annul_i = 1'b0;
    check("annul_on_stall", stallreq_o, 0);
    check("annul_on_hold", result_o, last_exp);
    r0 = n_ready;
    repeat (40) @(negedge clk);
    check("annul_on_no_ready", n_ready, r0);
    check("annul_on_hold_late", result_o, last_exp);
    do_op(1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D, "after_annul");

    // Annul while in DIVZERO.
    @(posedge clk);
    #1 start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'hCAFE; divisor_i = 32'd0;
    @(posedge clk);
    #1 start_i = 1'b0; annul_i = 1'b1;
    @(posedge clk);
    #1 annul_i = 1'b0;
    r0 = n_ready;
    repeat (5) @(negedge clk);
    check("annul_dz_no_ready", n_ready, r0);
    check("annul_dz_hold", result_o, last_exp);

    // start_i held through END: the second operation starts only from IDLE.
    @(posedge clk);
    #1 start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7;
    exp_q.push_back(64'h00000002_0000000E);
    exp_q.push_back(64'h00000002_0000000E);
    @(posedge clk);
    wait_ready(W + 1, "held_first");
    wait_ready(W + 2, "held_second");
    start_i = 1'b0;
    @(negedge clk);
    check("held_ready_once", ready_o, 0);

    // Asynchronous reset mid-operation with start_i held high.
    @(posedge clk);
    #1 start_i = 1'b1; signed_i = 1'b1; dividend_i = 32'hFFFFFFF9; divisor_i = 32'd2;
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_result", result_o, 0);
    check("midrst_ready", ready_o, 0);
    check("midrst_stall", stallreq_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.push_back(64'hFFFFFFFF_FFFFFFFD);
    #1;
    check("postrst_stall0", stallreq_o, 1);
    @(posedge clk);
    #1 start_i = 1'b0;
    wait_ready(W + 1, "postrst");
    @(negedge clk);
    check("postrst_ready_once", ready_o, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
